fib_arbiter: RTL and testbench
==============================

# fib_arbiter

Shares one `fib` sequence engine among NREQ requesters. Each request is a 4-bit index n. The block picks a winner by round-robin, drives the engine's start/n/pause inputs, and captures the 10-bit result on the engine's done pulse. It returns the result with the requester id through a valid/ready response port. It sits between client logic and a single `fib` instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): id width, derived, not overridden.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- hold  in  1  global freeze; drives eng_pause.
- req_valid  in  NREQ  per-requester request valid.
- req_n  in  4*NREQ  request index; slice i is [4*i+:4].
- req_ready  out  NREQ  one-hot accept strobe, combinational, IDLE only.
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  requester index of the result.
- rsp_f  out  10  result value.
- rsp_ready  in  1  consumer accepts the response.
- eng_start  out  1  to fib.start.
- eng_n  out  4  to fib.n; held at the latched n.
- eng_pause  out  1  to fib.pause.
- eng_busy  in  1  from fib.busy.
- eng_done  in  1  from fib.done.
- eng_f  in  10  from fib.f; valid only in the eng_done cycle.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, START, RUN, RESP.
- IDLE:
  - Accept only when all three hold: any req_valid, eng_busy==0, hold==0.
  - On accept, req_ready[w]=1 for the winner w only. Latch id=w and n=req_n[w]. Go to START.
  - An eng_done seen in IDLE is ignored and discarded.
- START: eng_start=1 for exactly one unheld cycle, then RUN. If hold=1, stay in START; the engine ignores start while paused.
- RUN: eng_start=0. On eng_done, rsp_f<=eng_f, rsp_id<=id, rsp_valid<=1, go to RESP.
- RESP: rsp_valid, rsp_id and rsp_f stay stable until rsp_ready=1. Then rsp_valid<=0 and go to IDLE.
- No new request is accepted before the response is consumed. One job is in flight at most.
- eng_n always equals the latched n. It is stable across START/RUN because the engine compares against it every cycle.
- eng_pause = hold in all states. While paused, the engine freezes and emits no done.
- Round-robin: search starts at (last+1) mod NREQ. last updates on accept only. Reset value of last is NREQ-1, so requester 0 wins first.
- Arithmetic: the engine returns F(n+1), with F(1)=F(2)=1. For n=15 the result is 987, which fits in 10 bits. The block performs no arithmetic on the result.
- Reset values: state=IDLE, eng_start=0, rsp_valid=0, rsp_id=0, rsp_f=0, latched n=0, busy=0, req_ready=0.
- Reset mid-job: the engine has no reset and may still be busy. The IDLE eng_busy==0 guard and the IDLE done-discard rule drain the stale job before the next start.

## Timing
- Accept in cycle 0; eng_start is high in cycle 1.
- Engine busy in cycles 2..n+2; eng_done in cycle n+3; rsp_valid high from cycle n+4.
- Each held cycle adds one cycle of latency.
- Back-to-back: the earliest next accept is the cycle after rsp_ready is sampled high.
- Requests not granted must keep req_valid and req_n stable until their req_ready strobe.

## Configuration
- FIB_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest asserted index wins; the last pointer is removed.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical.

## Structure
- Package fib_arb_pkg holds:
  - state enum (IDLE, START, RUN, RESP);
  - FIB_NW=4 and FIB_FW=10 width constants.
- Sub-module fib_rr_pick: combinational NREQ-wide rotating priority picker.
  - Inputs: req vector and last pointer.
  - Outputs: one-hot grant, encoded index and any-flag.
  - With FIB_ARB_FIXED_PRIO_EN it degenerates to a fixed-priority encoder.
- The bench instantiates the real `fib` module against the engine ports.

## Test plan
- Single request, id 2, n=4, rsp_ready=1 -> rsp_valid at cycle 8, rsp_id=2, rsp_f=5.
- n=0 -> rsp_f=1; n=15 -> rsp_f=987 with rsp_valid at cycle 19.
- All 4 requesters valid continuously, n=1 each -> grants in order 0,1,2,3,0. With FIB_ARB_FIXED_PRIO_EN, requester 0 is granted every time.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_f stay stable, req_ready stays 0, and no eng_start is issued.
- hold pulsed for 3 cycles during RUN with n=6 -> latency grows by 3, rsp_f=13. hold during START -> eng_start extended, engine starts once.
- rst_n asserted mid-RUN with n=15, then released with requester 1 valid -> no accept until eng_busy=0, the stale eng_done is discarded, and the new job returns the correct value.

Source files
------------

// File: rtl/fib_arb_pkg.sv
// fib_arb_pkg: shared types and widths for the fib engine arbiter.
// Build option: FIB_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package fib_arb_pkg;

    // Width of the engine index n and of the engine result f.
    localparam int FIB_NW = 4;
    localparam int FIB_FW = 10;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fib.sv
// fib: sequence engine shared by fib_arbiter. Returns F(n+1) with
// F(1)=F(2)=1. It has no reset; pause freezes all state and masks done.
module fib
    import fib_arb_pkg::*;
(
    input  logic              clk,
    input  logic              start,
    input  logic [FIB_NW-1:0] n,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic [FIB_FW-1:0] f
);

    logic              busy_q;
    logic              done_q;
    logic [FIB_NW-1:0] cnt_q;
    logic [FIB_FW-1:0] a_q;
    logic [FIB_FW-1:0] b_q;
    logic [FIB_FW-1:0] f_q;

    // Iterate a=F(cnt+1), b=F(cnt+2) until cnt reaches n, then pulse done.
    always_ff @(posedge clk) begin
        if (!pause) begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start) begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
                    a_q    <= FIB_FW'(1);
                    b_q    <= FIB_FW'(1);
                end
            end else if (cnt_q == n) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                f_q    <= a_q;
            end else begin
                a_q   <= b_q;
                b_q   <= a_q + b_q;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q & ~pause;
    assign f    = f_q;

endmodule

// File: rtl/fib_rr_pick.sv
// fib_rr_pick: combinational NREQ-wide request picker.
// Default: rotating priority starting one past the last winner.
// With FIB_ARB_FIXED_PRIO_EN defined: lowest asserted index wins and the
// last pointer input disappears.
module fib_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
`ifndef FIB_ARB_FIXED_PRIO_EN
    input  logic [IDW-1:0]  last,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_req
);

    logic [IDW-1:0] cand;

`ifndef FIB_ARB_FIXED_PRIO_EN
    // Scan from last+1 with wrap-around; the first asserted request wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
`else
    // Scan from index 0 upward; the lowest asserted request wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'(i);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/fib_arbiter.sv
// fib_arbiter: shares one fib engine among NREQ requesters and returns
// each result with its requester id over a valid/ready response port.
// Build option: FIB_ARB_FIXED_PRIO_EN (fixed priority, no last pointer).
module fib_arbiter
    import fib_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [FIB_NW*NREQ-1:0] req_n,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [FIB_FW-1:0]      rsp_f,
    input  logic                   rsp_ready,
    output logic                   eng_start,
    output logic [FIB_NW-1:0]      eng_n,
    output logic                   eng_pause,
    input  logic                   eng_busy,
    input  logic                   eng_done,
    input  logic [FIB_FW-1:0]      eng_f,
    output logic                   busy
);

    state_t            state_q;
    state_t            state_d;
    logic [IDW-1:0]    id_q;
    logic [FIB_NW-1:0] n_q;
    logic [NREQ-1:0]   pick_grant;
    logic [IDW-1:0]    pick_idx;
    logic              pick_any;
    logic              accept;
    logic [FIB_NW-1:0] req_n_arr [NREQ];

    // Split the flat request index bus into per-requester fields.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_n_arr[g] = req_n[FIB_NW*g +: FIB_NW];
    end

`ifndef FIB_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] last_q;

    fib_rr_pick #(.NREQ(NREQ)) u_pick (
        .last    (last_q),
        .req     (req_valid),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // Remember the last winner; reset so that requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
        end else if (accept) begin
            last_q <= pick_idx;
        end
    end
`else
    fib_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );
`endif

    // Accept only when idle, the engine has drained any stale job and no
    // freeze is active; rst_n keeps the strobe quiet while in reset.
    assign accept    = rst_n && (state_q == IDLE) && pick_any && !eng_busy && !hold;
    assign req_ready = accept ? pick_grant : '0;

    assign eng_start = (state_q == START);
    assign eng_n     = n_q;
    assign eng_pause = hold;
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an eng_done outside RUN is simply ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = START;
            START:   if (!hold)     state_d = RUN;
            RUN:     if (eng_done)  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Latch the winner's id and index; n stays on eng_n for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q <= '0;
            n_q  <= '0;
        end else if (accept) begin
            id_q <= pick_idx;
            n_q  <= req_n_arr[pick_idx];
        end
    end

    // Capture the result on done and hold it until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_f     <= '0;
        end else if (state_q == RUN && eng_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_f     <= eng_f;
        end else if (state_q == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: directed scoreboard bench for fib_arbiter driving a real
// fib engine. Also valid with FIB_ARB_FIXED_PRIO_EN defined.
module tb_fib_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold;
    logic              rsp_ready;
    logic [NREQ-1:0]   req_valid;
    logic [3:0]        tb_n [NREQ];
    logic [4*NREQ-1:0] req_n;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [9:0]        rsp_f;
    logic              eng_start;
    logic [3:0]        eng_n;
    logic              eng_pause;
    logic              eng_busy;
    logic              eng_done;
    logic [9:0]        eng_f;
    logic              busy;

    typedef struct {
        int id;
        int f;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    assign req_n = {tb_n[3], tb_n[2], tb_n[1], tb_n[0]};

    fib_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .rsp_ready (rsp_ready),
        .eng_start (eng_start),
        .eng_n     (eng_n),
        .eng_pause (eng_pause),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_f     (eng_f),
        .busy      (busy)
    );

    fib u_eng (
        .clk   (clk),
        .start (eng_start),
        .n     (eng_n),
        .pause (eng_pause),
        .busy  (eng_busy),
        .done  (eng_done),
        .f     (eng_f)
    );

    // Reference: F(n+1) with F(1)=F(2)=1.
    function automatic int fib_ref(input int n);
        int a = 1;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] id, input int n);
        req_valid[id] = 1'b1;
        tb_n[id]      = 4'(n);
    endtask

    // Wait (bounded) for an accept strobe, check the winner, queue the result.
    task automatic wait_grant(input string tag, input logic [1:0] exp_id, input int n);
        int k = 0;
        #1;
        while (req_ready == '0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check($sformatf("%s_grant", tag), 32'(req_ready), 32'(4'b0001 << exp_id));
        sb.push_back('{int'(exp_id), fib_ref(n)});
    endtask

    // From the accept cycle, run until rsp_valid (bounded); optionally
    // keep some requests, pulse hold, then check latency and the response.
    task automatic wait_rsp(input string tag, input int n, input int exp_lat,
                            input logic [3:0] keep, input int hold_from, input int hold_len);
        int   cyc    = 0;
        int   starts = 0;
        exp_t e;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req_valid = req_valid & keep;
            if (hold_len > 0 && cyc == hold_from) hold = 1'b1;
            if (hold_len > 0 && cyc == hold_from + hold_len) hold = 1'b0;
            #1;
            if (cyc == 1) begin
                check($sformatf("%s_start", tag), 32'(eng_start), 32'd1);
                check($sformatf("%s_eng_n", tag), 32'(eng_n), 32'(n));
            end
            if (hold_len > 0 && cyc == hold_from)
                check($sformatf("%s_pause", tag), 32'(eng_pause), 32'd1);
            if (eng_start && !hold) starts++;
        end while (!rsp_valid && cyc < 60);
        check($sformatf("%s_latency", tag), 32'(cyc), 32'(exp_lat));
        check($sformatf("%s_starts", tag), 32'(starts), 32'd1);
        e = '{-1, -1};
        if (sb.size() != 0) e = sb.pop_front();
        check($sformatf("%s_id", tag), 32'(rsp_id), e.id);
        check($sformatf("%s_f", tag), 32'(rsp_f), e.f);
    endtask

    initial begin
        int exp_id;
        int k;

        rst_n     = 1'b0;
        hold      = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) tb_n[i] = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_f", 32'(rsp_f), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_n", 32'(eng_n), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single jobs: n=4 (id 2), n=0 (id 0), n=15 (id 3).
        drive_req(2'd2, 4);
        wait_grant("n4", 2'd2, 4);
        wait_rsp("n4", 4, 8, 4'b0000, 0, 0);
        @(negedge clk);
        drive_req(2'd0, 0);
        wait_grant("n0", 2'd0, 0);
        wait_rsp("n0", 0, 4, 4'b0000, 0, 0);
        @(negedge clk);
        drive_req(2'd3, 15);
        wait_grant("n15", 2'd3, 15);
        wait_rsp("n15", 15, 19, 4'b0000, 0, 0);

        // Fresh reset, then all four requesters valid continuously with n=1.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) drive_req(2'(i), 1);
        for (int j = 0; j < 5; j++) begin
`ifdef FIB_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = j % NREQ;
`endif
            wait_grant($sformatf("arb%0d", j), 2'(exp_id), 1);
            wait_rsp($sformatf("arb%0d", j), 1, 5, (j == 4) ? 4'b0000 : 4'b1111, 0, 0);
        end

        // Response stall: consumer not ready for 10 cycles.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(2'd1, 2);
        wait_grant("stall", 2'd1, 2);
        wait_rsp("stall", 2, 6, 4'b0000, 0, 0);
        drive_req(2'd0, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_id", 32'(rsp_id), 32'd1);
            check("stall_f", 32'(rsp_f), 32'd2);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_eng_start", 32'(eng_start), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("stall_release_valid", 32'(rsp_valid), 32'd0);
        check("b2b_ready", 32'(req_ready), 32'd1);
        wait_grant("b2b", 2'd0, 3);
        wait_rsp("b2b", 3, 7, 4'b0000, 0, 0);

        // Hold for 3 cycles during RUN, n=6.
        @(negedge clk);
        drive_req(2'd3, 6);
        wait_grant("hold_run", 2'd3, 6);
        wait_rsp("hold_run", 6, 13, 4'b0000, 4, 3);

        // Hold for 2 cycles during START, n=5.
        @(negedge clk);
        drive_req(2'd2, 5);
        wait_grant("hold_start", 2'd2, 5);
        wait_rsp("hold_start", 5, 11, 4'b0000, 1, 2);

        // Reset mid-RUN with n=15; the engine keeps running the stale job.
        @(negedge clk);
        drive_req(2'd2, 15);
        wait_grant("abort", 2'd2, 15);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(2'd1, 7);
        #1;
        k = 0;
        while (eng_busy && k < 40) begin
            check("drain_req_ready", 32'(req_ready), 32'd0);
            check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            #1;
            k++;
        end
        check("drain_seen_busy", 32'(k > 0), 32'd1);
        check("drain_stale_done", 32'(eng_done), 32'd1);
        check("drain_no_rsp", 32'(rsp_valid), 32'd0);
        wait_grant("after_rst", 2'd1, 7);
        wait_rsp("after_rst", 7, 11, 4'b0000, 0, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
